cc_speed_limit_writer: RTL and testbench
========================================

CC_SPEED_LIMIT_WRITER -- requirements
Module: cc_speed_limit_writer

Interface
REQ-001 The block SHALL have parameter DATAWIDTH, default 8: width of the speed and limit buses.
REQ-002 The block SHALL have parameter SETUP_CYCLES, default 1, range 1..15: cycles the limit bus is stable before the load strobe falls.
REQ-003 The block SHALL have parameter STROBE_CYCLES, default 2, range 1..15: cycles the load strobe is held low.
REQ-004 The block SHALL have parameter RESET_LIMIT, default 200: limit written automatically after reset.
REQ-005 The block SHALL have port CC_SPEED_LIMIT_WRITER_CLOCK_50  in  1  system clock; the block uses one clock only.
REQ-006 The block SHALL have port CC_SPEED_LIMIT_WRITER_RESET_InLow  in  1  reset; asynchronous assertion, active-low.
REQ-007 The block SHALL have port CC_SPEED_LIMIT_WRITER_limitWrite_InLow  in  1  write request, synchronous; a falling edge requests one write.
REQ-008 The block SHALL have port CC_SPEED_LIMIT_WRITER_limitValue_InBUS  in  DATAWIDTH  new limit value, sampled on the request edge.
REQ-009 The block SHALL have port CC_SPEED_LIMIT_WRITER_speedUp_InLow  in  1  increment request, synchronous, falling-edge triggered.
REQ-010 The block SHALL have port CC_SPEED_LIMIT_WRITER_speedDown_InLow  in  1  decrement request, synchronous, falling-edge triggered.
REQ-011 The block SHALL have port CC_SPEED_LIMIT_WRITER_speed_OutBUS  out  DATAWIDTH  current speed, registered; drives the comparator data bus.
REQ-012 The block SHALL have port CC_SPEED_LIMIT_WRITER_limit_OutBUS  out  DATAWIDTH  limit value, registered; drives the comparator limit bus.
REQ-013 The block SHALL have port CC_SPEED_LIMIT_WRITER_loadSignal_OutLow  out  1  load strobe, registered; the comparator captures the limit on its falling edge.
REQ-014 The block SHALL have port CC_SPEED_LIMIT_WRITER_busy_OutHigh  out  1  high whenever the FSM is not in IDLE.

Function
REQ-015 Edge detect: each *_InLow input SHALL be registered once; an edge is previous sample 1 and current input 0; detector registers SHALL reset to 1.
REQ-016 FSM states SHALL be IDLE, SETUP, STROBE and HOLD; the FSM SHALL move IDLE->SETUP on a write edge, capturing limitValue into limit_OutBUS on that clock edge.
REQ-017 SETUP SHALL last SETUP_CYCLES cycles with loadSignal high, then the FSM SHALL move to STROBE.
REQ-018 STROBE SHALL last STROBE_CYCLES cycles with loadSignal low, then the FSM SHALL move to HOLD.
REQ-019 HOLD SHALL last 1 cycle with loadSignal high, then the FSM SHALL move to IDLE or to SETUP if pending.
REQ-020 Timing, for a request edge seen at clock edge n: loadSignal SHALL fall at edge n+SETUP_CYCLES and rise at n+SETUP_CYCLES+STROBE_CYCLES, and busy SHALL drop at n+SETUP_CYCLES+STROBE_CYCLES+1.
REQ-021 limit_OutBUS SHALL NOT change from entry to SETUP until exit from HOLD.
REQ-022 A write edge arriving while busy SHALL set a one-deep pending flag and store the value in a pending register.
REQ-023 A further write edge arriving while pending SHALL overwrite the pending value, last-wins; no request SHALL be dropped silently except by overwrite.
REQ-024 On HOLD exit with pending set, the pending value SHALL load into limit_OutBUS, pending SHALL clear and the FSM SHALL enter SETUP with no IDLE cycle.
REQ-025 A write edge in the same cycle as HOLD exit with pending set SHALL become the new pending entry.
REQ-026 Speed counter: an up edge SHALL add 1, saturating at 2^DATAWIDTH-1; a down edge SHALL subtract 1, saturating at 0; up and down edges in the same cycle SHALL cause no change.
REQ-027 The speed counter SHALL update in every FSM state, independent of the FSM.

Reset
REQ-028 Reset assertion SHALL asynchronously force: speed_OutBUS=0, limit_OutBUS=RESET_LIMIT, loadSignal_OutLow=1, busy_OutHigh=1, state=SETUP (cycle count 0), pending=0.
REQ-029 After reset release, the block SHALL therefore perform one automatic write of RESET_LIMIT with the normal timing.
REQ-030 Reset mid-strobe SHALL return loadSignal high immediately; the in-flight write and pending request SHALL be discarded.

Structure
REQ-031 State encoding and the default SETUP/STROBE/RESET_LIMIT constants SHALL live in a shared package cc_speed_pkg, shared with the comparator's width default.
REQ-032 One sub-module, cc_edge_detect_low (registered falling-edge detector), SHALL be instantiated three times; everything else SHALL be flat.

Verification
REQ-033 Reset release with defaults -> busy=1; loadSignal low for exactly 2 cycles starting 1 cycle after release; limit_OutBUS=200 throughout; busy=0 at cycle 4.
REQ-034 Idle, write edge with value 0x50 -> limit_OutBUS=0x50 next edge; loadSignal low cycles 1-2 after request; paired comparator captures 0x50.
REQ-035 Write 0x10, then 0x20 and 0x30 during the strobe -> two strobes back to back, limits 0x10 then 0x30; 0x20 is never driven.
REQ-036 Speed 0 and 3 down edges -> stays 0; speed 254 and 3 up edges -> 255; simultaneous up+down at 100 -> 100.
REQ-037 Reset asserted in STROBE with pending set -> loadSignal=1 asynchronously; after release only the RESET_LIMIT write occurs.
REQ-038 Continuous low on limitWrite for 20 cycles -> exactly one write.

Source files
------------

// File: rtl/cc_speed_pkg.sv
// Shared constants and types for the cruise-control speed/limit path.
// Holds the default bus width (also used by the comparator), the default
// write timing, the power-on limit and the writer FSM state encoding.
package cc_speed_pkg;

    localparam int unsigned CC_DATAWIDTH     = 8;
    localparam int unsigned CC_SETUP_CYCLES  = 1;
    localparam int unsigned CC_STROBE_CYCLES = 2;
    localparam int unsigned CC_RESET_LIMIT   = 200;

    // Phase counters cover the 1..15 cycle range of both timing parameters
    localparam int unsigned CC_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } cc_state_e;

    // Terminal count for a phase lasting 'cycles' clock cycles
    function automatic logic [CC_CNT_W-1:0] cc_last_cnt(input int unsigned cycles);
        return CC_CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/cc_speed_limit_writer_if.sv
// Bus bundle between the limit writer and its environment.
//   requests (in to the writer) : limitWrite_InLow, limitValue_InBUS,
//                                 speedUp_InLow, speedDown_InLow
//   results  (out of the writer): speed_OutBUS, limit_OutBUS,
//                                 loadSignal_OutLow, busy_OutHigh
// master = requester side, slave = writer side.
interface cc_speed_limit_writer_if
    import cc_speed_pkg::*;
#(
    parameter int unsigned DATAWIDTH = CC_DATAWIDTH
);

    logic                 CC_SPEED_LIMIT_WRITER_limitWrite_InLow;
    logic [DATAWIDTH-1:0] CC_SPEED_LIMIT_WRITER_limitValue_InBUS;
    logic                 CC_SPEED_LIMIT_WRITER_speedUp_InLow;
    logic                 CC_SPEED_LIMIT_WRITER_speedDown_InLow;
    logic [DATAWIDTH-1:0] CC_SPEED_LIMIT_WRITER_speed_OutBUS;
    logic [DATAWIDTH-1:0] CC_SPEED_LIMIT_WRITER_limit_OutBUS;
    logic                 CC_SPEED_LIMIT_WRITER_loadSignal_OutLow;
    logic                 CC_SPEED_LIMIT_WRITER_busy_OutHigh;

    modport master (
        output CC_SPEED_LIMIT_WRITER_limitWrite_InLow,
        output CC_SPEED_LIMIT_WRITER_limitValue_InBUS,
        output CC_SPEED_LIMIT_WRITER_speedUp_InLow,
        output CC_SPEED_LIMIT_WRITER_speedDown_InLow,
        input  CC_SPEED_LIMIT_WRITER_speed_OutBUS,
        input  CC_SPEED_LIMIT_WRITER_limit_OutBUS,
        input  CC_SPEED_LIMIT_WRITER_loadSignal_OutLow,
        input  CC_SPEED_LIMIT_WRITER_busy_OutHigh
    );

    modport slave (
        input  CC_SPEED_LIMIT_WRITER_limitWrite_InLow,
        input  CC_SPEED_LIMIT_WRITER_limitValue_InBUS,
        input  CC_SPEED_LIMIT_WRITER_speedUp_InLow,
        input  CC_SPEED_LIMIT_WRITER_speedDown_InLow,
        output CC_SPEED_LIMIT_WRITER_speed_OutBUS,
        output CC_SPEED_LIMIT_WRITER_limit_OutBUS,
        output CC_SPEED_LIMIT_WRITER_loadSignal_OutLow,
        output CC_SPEED_LIMIT_WRITER_busy_OutHigh
    );

endinterface

// File: rtl/cc_edge_detect_low.sv
// Registered falling-edge detector for an active-low request line.
//   clk, rst_n : clock, async active-low reset
//   i_sig_n    : synchronous active-low request
//   o_fall_c   : combinational pulse, high when last sample was 1 and the
//                current input is 0
// The history register resets to 1 so a line held low through reset
// registers as one request after release.
module cc_edge_detect_low (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sig_n,
    output logic o_fall_c
);

    logic r_prev;

    // One-sample history of the request line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= i_sig_n;
        end
    end

    assign o_fall_c = r_prev & ~i_sig_n;

endmodule

// File: rtl/cc_speed_limit_writer.sv
// Cruise-control speed/limit writer.
// Keeps a saturating speed counter driven by up/down request edges and
// writes new limit values to a downstream comparator with a
// setup / load-strobe / hold sequence. One write may queue behind the one
// in flight (last request wins). Reset starts an automatic write of
// RESET_LIMIT.
//   CC_SPEED_LIMIT_WRITER_CLOCK_50    : system clock
//   CC_SPEED_LIMIT_WRITER_RESET_InLow : async active-low reset
//   bus (slave)                       : request inputs, speed/limit buses,
//                                       load strobe, busy
module cc_speed_limit_writer
    import cc_speed_pkg::*;
#(
    parameter int unsigned DATAWIDTH     = CC_DATAWIDTH,
    parameter int unsigned SETUP_CYCLES  = CC_SETUP_CYCLES,
    parameter int unsigned STROBE_CYCLES = CC_STROBE_CYCLES,
    parameter int unsigned RESET_LIMIT   = CC_RESET_LIMIT
) (
    input  logic                    CC_SPEED_LIMIT_WRITER_CLOCK_50,
    input  logic                    CC_SPEED_LIMIT_WRITER_RESET_InLow,
    cc_speed_limit_writer_if.slave  bus
);

    localparam int unsigned             CNT_W       = CC_CNT_W;
    localparam logic [CNT_W-1:0]        LAST_SETUP  = cc_last_cnt(SETUP_CYCLES);
    localparam logic [CNT_W-1:0]        LAST_STROBE = cc_last_cnt(STROBE_CYCLES);
    localparam logic [DATAWIDTH-1:0]    SPEED_MAX   = '1;
    localparam logic [DATAWIDTH-1:0]    LIMIT_INIT  = DATAWIDTH'(RESET_LIMIT);

    logic w_wr_edge;
    logic w_up_edge;
    logic w_dn_edge;

    cc_edge_detect_low u_wr_edge (
        .clk      (CC_SPEED_LIMIT_WRITER_CLOCK_50),
        .rst_n    (CC_SPEED_LIMIT_WRITER_RESET_InLow),
        .i_sig_n  (bus.CC_SPEED_LIMIT_WRITER_limitWrite_InLow),
        .o_fall_c (w_wr_edge)
    );

    cc_edge_detect_low u_up_edge (
        .clk      (CC_SPEED_LIMIT_WRITER_CLOCK_50),
        .rst_n    (CC_SPEED_LIMIT_WRITER_RESET_InLow),
        .i_sig_n  (bus.CC_SPEED_LIMIT_WRITER_speedUp_InLow),
        .o_fall_c (w_up_edge)
    );

    cc_edge_detect_low u_dn_edge (
        .clk      (CC_SPEED_LIMIT_WRITER_CLOCK_50),
        .rst_n    (CC_SPEED_LIMIT_WRITER_RESET_InLow),
        .i_sig_n  (bus.CC_SPEED_LIMIT_WRITER_speedDown_InLow),
        .o_fall_c (w_dn_edge)
    );

    cc_state_e            r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [DATAWIDTH-1:0] r_limit;
    logic [DATAWIDTH-1:0] r_pend_val;
    logic                 r_pending;
    logic                 r_load_n;
    logic                 r_busy;
    logic [DATAWIDTH-1:0] r_speed;

    // Saturating speed counter; runs regardless of the write sequence
    always_ff @(posedge CC_SPEED_LIMIT_WRITER_CLOCK_50 or negedge CC_SPEED_LIMIT_WRITER_RESET_InLow) begin
        if (!CC_SPEED_LIMIT_WRITER_RESET_InLow) begin
            r_speed <= '0;
        end else if (w_up_edge && !w_dn_edge && (r_speed != SPEED_MAX)) begin
            r_speed <= r_speed + DATAWIDTH'(1);
        end else if (w_dn_edge && !w_up_edge && (r_speed != '0)) begin
            r_speed <= r_speed - DATAWIDTH'(1);
        end
    end

    // Limit write sequencer: IDLE -> SETUP -> STROBE -> HOLD -> IDLE/SETUP
    always_ff @(posedge CC_SPEED_LIMIT_WRITER_CLOCK_50 or negedge CC_SPEED_LIMIT_WRITER_RESET_InLow) begin
        if (!CC_SPEED_LIMIT_WRITER_RESET_InLow) begin
            r_state    <= ST_SETUP;
            r_cnt      <= '0;
            r_limit    <= LIMIT_INIT;
            r_pend_val <= '0;
            r_pending  <= 1'b0;
            r_load_n   <= 1'b1;
            r_busy     <= 1'b1;
        end else begin
            // A request during a write parks in the one-deep slot; later ones overwrite it
            if (w_wr_edge && (r_state != ST_IDLE)) begin
                r_pending  <= 1'b1;
                r_pend_val <= bus.CC_SPEED_LIMIT_WRITER_limitValue_InBUS;
            end

            case (r_state)
                ST_IDLE: begin
                    // A fresh request is newer than anything parked, so it takes priority
                    if (w_wr_edge) begin
                        r_limit   <= bus.CC_SPEED_LIMIT_WRITER_limitValue_InBUS;
                        r_pending <= 1'b0;
                        r_state   <= ST_SETUP;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                    end else if (r_pending) begin
                        r_limit   <= r_pend_val;
                        r_pending <= 1'b0;
                        r_state   <= ST_SETUP;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                    end
                end

                ST_SETUP: begin
                    if (r_cnt == LAST_SETUP) begin
                        r_state  <= ST_STROBE;
                        r_cnt    <= '0;
                        r_load_n <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                ST_STROBE: begin
                    if (r_cnt == LAST_STROBE) begin
                        r_state  <= ST_HOLD;
                        r_cnt    <= '0;
                        r_load_n <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                ST_HOLD: begin
                    // Chain straight into the parked write; a request on this same
                    // edge becomes the next parked entry
                    if (r_pending) begin
                        r_limit   <= r_pend_val;
                        r_pending <= w_wr_edge;
                        r_state   <= ST_SETUP;
                        r_cnt     <= '0;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state  <= ST_IDLE;
                    r_cnt    <= '0;
                    r_load_n <= 1'b1;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.CC_SPEED_LIMIT_WRITER_speed_OutBUS      = r_speed;
    assign bus.CC_SPEED_LIMIT_WRITER_limit_OutBUS      = r_limit;
    assign bus.CC_SPEED_LIMIT_WRITER_loadSignal_OutLow = r_load_n;
    assign bus.CC_SPEED_LIMIT_WRITER_busy_OutHigh      = r_busy;

endmodule

// File: tb/tb_cc_speed_limit_writer.sv
// Self-checking bench for cc_speed_limit_writer. A transaction-level model
// (write age timeline, one parked request, integer speed) predicts every
// output each cycle; directed sequences plus random traffic drive it.
module tb_cc_speed_limit_writer;

    localparam int unsigned DW    = 8;
    localparam int unsigned SET_C = 1;
    localparam int unsigned STR_C = 2;
    localparam int unsigned RLIM  = 200;
    localparam int          VMAX  = (1 << DW) - 1;

    logic clk;
    logic rst_n;
    logic in_wr;
    logic in_up;
    logic in_dn;
    logic [DW-1:0] in_val;

    cc_speed_limit_writer_if #(.DATAWIDTH(DW)) bus ();

    assign bus.CC_SPEED_LIMIT_WRITER_limitWrite_InLow = in_wr;
    assign bus.CC_SPEED_LIMIT_WRITER_limitValue_InBUS = in_val;
    assign bus.CC_SPEED_LIMIT_WRITER_speedUp_InLow    = in_up;
    assign bus.CC_SPEED_LIMIT_WRITER_speedDown_InLow  = in_dn;

    cc_speed_limit_writer #(
        .DATAWIDTH     (DW),
        .SETUP_CYCLES  (SET_C),
        .STROBE_CYCLES (STR_C),
        .RESET_LIMIT   (RLIM)
    ) dut (
        .CC_SPEED_LIMIT_WRITER_CLOCK_50    (clk),
        .CC_SPEED_LIMIT_WRITER_RESET_InLow (rst_n),
        .bus                               (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_speed;
    int m_limit;
    bit m_active;     // a write is in flight
    int m_age;        // clock edges since that write was launched
    bit m_pend;
    int m_pend_val;
    bit m_pw, m_pu, m_pd;

    task automatic model_reset();
        m_speed    = 0;
        m_limit    = RLIM;
        m_active   = 1'b1;
        m_age      = 0;
        m_pend     = 1'b0;
        m_pend_val = 0;
        m_pw = 1'b1; m_pu = 1'b1; m_pd = 1'b1;
    endtask

    task automatic model_launch(input int v);
        m_limit  = v;
        m_active = 1'b1;
        m_age    = 0;
    endtask

    task automatic model_step();
        bit we, ue, de, was_active;
        int old_pend;
        we = m_pw && !in_wr;
        ue = m_pu && !in_up;
        de = m_pd && !in_dn;
        if (ue && !de && m_speed < VMAX) m_speed++;
        else if (de && !ue && m_speed > 0) m_speed--;

        was_active = m_active;
        if (m_active) begin
            m_age++;
            if (m_age == int'(SET_C + STR_C + 1)) m_active = 1'b0;
        end
        if (was_active) begin
            if (!m_active && m_pend) begin
                old_pend = m_pend_val;
                model_launch(old_pend);
                m_pend = we;
                if (we) m_pend_val = int'(in_val);
            end else if (we) begin
                m_pend     = 1'b1;
                m_pend_val = int'(in_val);
            end
        end else begin
            if (we) begin
                model_launch(int'(in_val));
                m_pend = 1'b0;
            end else if (m_pend) begin
                model_launch(m_pend_val);
                m_pend = 1'b0;
            end
        end
        m_pw = in_wr; m_pu = in_up; m_pd = in_dn;
    endtask

    function automatic bit model_load_n();
        return !(m_active && m_age >= int'(SET_C) && m_age < int'(SET_C + STR_C));
    endfunction

    // ---------------- observation ----------------
    int   cap_q[$];       // limit values seen on each load-strobe fall
    logic obs_prev_load = 1'b1;

    task automatic compare_all();
        check_eq("speed",  32'(bus.CC_SPEED_LIMIT_WRITER_speed_OutBUS), 32'(m_speed));
        check_eq("limit",  32'(bus.CC_SPEED_LIMIT_WRITER_limit_OutBUS), 32'(m_limit));
        check_eq("load_n", 32'(bus.CC_SPEED_LIMIT_WRITER_loadSignal_OutLow), 32'(model_load_n()));
        check_eq("busy",   32'(bus.CC_SPEED_LIMIT_WRITER_busy_OutHigh), 32'(m_active));
        if (obs_prev_load && !bus.CC_SPEED_LIMIT_WRITER_loadSignal_OutLow)
            cap_q.push_back(int'(bus.CC_SPEED_LIMIT_WRITER_limit_OutBUS));
        obs_prev_load = bus.CC_SPEED_LIMIT_WRITER_loadSignal_OutLow;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    // Asserts reset between edges, checks the asynchronous values, releases later
    task automatic apply_reset(input int hold_edges);
        in_wr = 1'b1; in_up = 1'b1; in_dn = 1'b1;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        repeat (hold_edges) @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    task automatic write_pulse(input int v);
        in_val = DW'(v);
        in_wr  = 1'b0;
        tick();
        in_wr  = 1'b1;
        in_val = DW'($urandom);
        tick();
    endtask

    task automatic speed_pulse(input bit up, input bit dn);
        in_up = !up;
        in_dn = !dn;
        tick();
        in_up = 1'b1;
        in_dn = 1'b1;
        tick();
    endtask

    function automatic int cap_at(input int i);
        return (cap_q.size() > i) ? cap_q[i] : -1;
    endfunction

    initial begin
        in_wr = 1'b1; in_up = 1'b1; in_dn = 1'b1; in_val = '0;
        rst_n = 1'b1;
        #1;

        // Power-on: automatic write of the reset limit
        apply_reset(1);
        cap_q.delete();
        repeat (6) tick();
        check_eq("por_capture_cnt", 32'(cap_q.size()), 32'd1);
        check_eq("por_capture_val", 32'(cap_at(0)), 32'd200);

        // Single write from idle; value visible on the very next edge
        in_val = DW'(8'h50);
        in_wr  = 1'b0;
        tick();
        check_eq("wr50_limit_next", 32'(bus.CC_SPEED_LIMIT_WRITER_limit_OutBUS), 32'h50);
        in_wr = 1'b1;
        repeat (6) tick();

        // Back-to-back requests: parked entry chains, later request overwrites parked one
        cap_q.delete();
        write_pulse(8'h10);
        write_pulse(8'h20);
        write_pulse(8'h30);
        write_pulse(8'h40);
        repeat (16) tick();
        check_eq("chain_cnt",  32'(cap_q.size()), 32'd3);
        check_eq("chain_cap0", 32'(cap_at(0)), 32'h10);
        check_eq("chain_cap1", 32'(cap_at(1)), 32'h20);
        check_eq("chain_cap2", 32'(cap_at(2)), 32'h40);

        // Write line held low: one write only
        cap_q.delete();
        in_val = DW'(8'h77);
        in_wr  = 1'b0;
        repeat (20) tick();
        in_wr = 1'b1;
        repeat (6) tick();
        check_eq("held_low_writes", 32'(cap_q.size()), 32'd1);

        // Speed saturation at both ends and simultaneous up/down
        repeat (3) speed_pulse(1'b0, 1'b1);
        check_eq("speed_floor", 32'(bus.CC_SPEED_LIMIT_WRITER_speed_OutBUS), 32'd0);
        repeat (254) speed_pulse(1'b1, 1'b0);
        check_eq("speed_254", 32'(bus.CC_SPEED_LIMIT_WRITER_speed_OutBUS), 32'd254);
        repeat (3) speed_pulse(1'b1, 1'b0);
        check_eq("speed_ceiling", 32'(bus.CC_SPEED_LIMIT_WRITER_speed_OutBUS), 32'd255);
        repeat (155) speed_pulse(1'b0, 1'b1);
        speed_pulse(1'b1, 1'b1);
        check_eq("speed_both", 32'(bus.CC_SPEED_LIMIT_WRITER_speed_OutBUS), 32'd100);

        // Speed keeps counting while a write is in flight
        in_val = DW'(8'h33);
        in_wr  = 1'b0;
        in_up  = 1'b0;
        tick();
        in_wr = 1'b1;
        in_up = 1'b1;
        tick();
        check_eq("speed_busy", 32'(bus.CC_SPEED_LIMIT_WRITER_speed_OutBUS), 32'd101);
        repeat (6) tick();

        // Reset during the strobe with a parked request
        write_pulse(8'h11);
        in_val = DW'(8'h22);
        in_wr  = 1'b0;
        tick();
        check_eq("mid_strobe_load", 32'(bus.CC_SPEED_LIMIT_WRITER_loadSignal_OutLow), 32'd0);
        apply_reset(2);
        check_eq("rst_async_load", 32'(bus.CC_SPEED_LIMIT_WRITER_loadSignal_OutLow), 32'd1);
        cap_q.delete();
        repeat (10) tick();
        check_eq("rst_capture_cnt", 32'(cap_q.size()), 32'd1);
        check_eq("rst_capture_val", 32'(cap_at(0)), 32'd200);

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            in_wr  = ($urandom_range(0, 3) != 0);
            in_up  = ($urandom_range(0, 2) != 0);
            in_dn  = ($urandom_range(0, 2) != 0);
            in_val = DW'($urandom);
            if ($urandom_range(0, 499) == 0) apply_reset(int'($urandom_range(1, 2)));
            else tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
